// File: rtl/wave_capture_pkg.sv
// Shared types, widths and sample-to-pixel conversion for the wave capture sequencer.
package wave_capture_pkg;

  localparam int unsigned SAMPLES_PER_BUF = 256;
  localparam int unsigned WAVE_ADDR_W     = 9;
  localparam int unsigned COUNT_W         = WAVE_ADDR_W - 1;
  localparam int unsigned SAMPLE_W        = 16;
  localparam int unsigned PIXEL_W         = 8;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic [PIXEL_W-1:0] mix;
    logic [PIXEL_W-1:0] v1;
    logic [PIXEL_W-1:0] v2;
    logic [PIXEL_W-1:0] v3;
  } pix_set_t;

  // Signed sample to unsigned display row: flip the sign bit, keep the top magnitude bits.
  function automatic logic [PIXEL_W-1:0] to_pixel(input logic [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2 -: PIXEL_W-1]};
  endfunction

endpackage

// File: rtl/wave_capture_if.sv
// Sample stream in / sample RAM write port out for the wave capture sequencer.
interface wave_capture_if;
  import wave_capture_pkg::*;

  logic                   new_sample_ready;
  logic [SAMPLE_W-1:0]    new_sample_in;
  logic [SAMPLE_W-1:0]    sample_v1;
  logic [SAMPLE_W-1:0]    sample_v2;
  logic [SAMPLE_W-1:0]    sample_v3;
  logic                   wave_display_idle;

  logic [WAVE_ADDR_W-1:0] write_address;
  logic                   write_enable;
  logic [PIXEL_W-1:0]     write_sample;
  logic [PIXEL_W-1:0]     write_sample_v1;
  logic [PIXEL_W-1:0]     write_sample_v2;
  logic [PIXEL_W-1:0]     write_sample_v3;
  logic                   read_index;
  logic                   capture_done;

  modport master (
    input  new_sample_ready, new_sample_in, sample_v1, sample_v2, sample_v3, wave_display_idle,
    output write_address, write_enable, write_sample, write_sample_v1, write_sample_v2,
           write_sample_v3, read_index, capture_done
  );

  modport slave (
    output new_sample_ready, new_sample_in, sample_v1, sample_v2, sample_v3, wave_display_idle,
    input  write_address, write_enable, write_sample, write_sample_v1, write_sample_v2,
           write_sample_v3, read_index, capture_done
  );

endinterface

// File: rtl/wave_trigger_det.sv
// Rising zero-crossing detector on the combined sample sign; history updates on every strobe.
module wave_trigger_det (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic sample_sign,
  output logic rise_c
);

  logic prev_sign_q, prev_sign_d;
  logic prev_valid_q, prev_valid_d;

  always_comb begin
    prev_sign_d  = prev_sign_q;
    prev_valid_d = prev_valid_q;
    if (strobe) begin
      prev_sign_d  = sample_sign;
      prev_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_sign_q  <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      prev_sign_q  <= prev_sign_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  // Negative to non-negative; zero counts as non-negative.
  assign rise_c = prev_valid_q && prev_sign_q && !sample_sign;

endmodule

// File: rtl/wave_capture_ctrl.sv
// Capture sequencer: trigger on rising crossing, fill back buffer, flip buffers during display idle.
// Optional forced trigger after AUTO_TIMEOUT armed strobes when WAVE_CAPTURE_AUTOTRIG_EN is defined.
module wave_capture_ctrl
  import wave_capture_pkg::*;
#(
  parameter int unsigned AUTO_TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  wave_capture_if.master bus
);

  cap_state_e             state_q, state_d;
  logic [COUNT_W-1:0]     count_q, count_d;
  logic                   read_index_q, read_index_d;
  logic                   write_enable_q, write_enable_d;
  logic [WAVE_ADDR_W-1:0] write_address_q, write_address_d;
  pix_set_t               write_data_q, write_data_d;
  logic                   capture_done_q, capture_done_d;

  logic                   rise_c;
  logic                   timeout_c;
  logic                   trig_c;
  pix_set_t               cur_pix_c;

  wave_trigger_det u_trig (
    .clk         (clk),
    .reset       (reset),
    .strobe      (bus.new_sample_ready),
    .sample_sign (bus.new_sample_in[SAMPLE_W-1]),
    .rise_c      (rise_c)
  );

  if (AUTO_TIMEOUT == 0) begin : g_zero_timeout_unsupported
  end

`ifdef WAVE_CAPTURE_AUTOTRIG_EN
  localparam int unsigned TO_W =
    ($clog2(AUTO_TIMEOUT + 1) > 11) ? $clog2(AUTO_TIMEOUT + 1) : 11;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // The strobe that would make the count reach AUTO_TIMEOUT forces the trigger.
  assign timeout_c = (to_cnt_q == TO_W'(AUTO_TIMEOUT - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q != ARMED)          to_cnt_d = '0;
    else if (bus.new_sample_ready) to_cnt_d = trig_c ? '0 : to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  assign trig_c    = rise_c || timeout_c;
  assign cur_pix_c = {to_pixel(bus.new_sample_in), to_pixel(bus.sample_v1),
                      to_pixel(bus.sample_v2), to_pixel(bus.sample_v3)};

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    read_index_d    = read_index_q;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    capture_done_d  = 1'b0;

    unique case (state_q)
      ARMED: begin
        if (bus.new_sample_ready && trig_c) begin
          write_enable_d  = 1'b1;
          write_address_d = {~read_index_q, count_q};
          write_data_d    = cur_pix_c;
          count_d         = COUNT_W'(1);
          state_d         = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.new_sample_ready) begin
          write_enable_d  = 1'b1;
          write_address_d = {~read_index_q, count_q};
          write_data_d    = cur_pix_c;
          count_d         = count_q + COUNT_W'(1);
          if (count_q == COUNT_W'(SAMPLES_PER_BUF - 1)) state_d = WAIT;
        end
      end
      WAIT: begin
        // Flip only while the display is blanked so it never sees a partial buffer.
        if (bus.wave_display_idle) begin
          read_index_d   = ~read_index_q;
          capture_done_d = 1'b1;
          count_d        = '0;
          state_d        = ARMED;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ARMED;
      count_q         <= '0;
      read_index_q    <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      capture_done_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      read_index_q    <= read_index_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      capture_done_q  <= capture_done_d;
    end
  end

  assign bus.write_address   = write_address_q;
  assign bus.write_enable    = write_enable_q;
  assign bus.write_sample    = write_data_q.mix;
  assign bus.write_sample_v1 = write_data_q.v1;
  assign bus.write_sample_v2 = write_data_q.v2;
  assign bus.write_sample_v3 = write_data_q.v3;
  assign bus.read_index      = read_index_q;
  assign bus.capture_done    = capture_done_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Bench for wave_capture_ctrl: randomized strobes against a sample-history reference model.
module tb_wave_capture_ctrl;

  localparam int unsigned TB_TIMEOUT = 1024;
  localparam int PH_ARMED = 0, PH_CAPTURE = 1, PH_WAIT = 2;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] mix;
    logic [7:0] v1;
    logic [7:0] v2;
    logic [7:0] v3;
  } wr_t;

  logic clk = 1'b0;
  logic reset;

  wave_capture_if wif ();

  wave_capture_ctrl #(.AUTO_TIMEOUT(TB_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (wif)
  );

  always #5 clk = ~clk;

  int   compared   = 0;
  int   mismatched = 0;
  int   done_seen  = 0;
  wr_t  act_q[$];
  wr_t  exp_q[$];
  wr_t  last_wr;

  int         m_phase, m_k, m_done;
  bit         m_ri, m_prev_valid;
  logic [15:0] m_prev;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
  int         m_armed;
`endif

  // Display row = (sample + 32768) / 256.
  function automatic logic [7:0] pix(input logic [15:0] s);
    int v;
    v = int'($signed(s)) + 32768;
    return 8'(v / 256);
  endfunction

  function automatic void model_reset();
    m_phase = PH_ARMED; m_k = 0; m_ri = 1'b0; m_prev_valid = 1'b0; m_prev = '0;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
    m_armed = 0;
`endif
  endfunction

  // One clock cycle of stimulus; the model decides from the phase at the start of the cycle.
  task automatic drive(input bit stb, input logic [15:0] s, input bit idle);
    logic [15:0] v1, v2, v3;
    bit  trig;
    wr_t w;
    v1 = 16'($urandom); v2 = 16'($urandom); v3 = 16'($urandom);
    wif.new_sample_ready  = stb;
    wif.new_sample_in     = s;
    wif.sample_v1         = v1;
    wif.sample_v2         = v2;
    wif.sample_v3         = v3;
    wif.wave_display_idle = idle;
    w.addr = 9'((m_ri ? 0 : 256) + m_k);
    w.mix = pix(s); w.v1 = pix(v1); w.v2 = pix(v2); w.v3 = pix(v3);
    trig = 1'b0;
    case (m_phase)
      PH_WAIT: if (idle) begin
        m_phase = PH_ARMED; m_ri = ~m_ri; m_done++; m_k = 0;
      end
      PH_ARMED: if (stb) begin
        trig = m_prev_valid && ($signed(m_prev) < 0) && ($signed(s) >= 0);
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
        m_armed++;
        if (m_armed == int'(TB_TIMEOUT)) trig = 1'b1;
        if (trig) m_armed = 0;
`endif
        if (trig) begin
          exp_q.push_back(w); m_k = 1; m_phase = PH_CAPTURE;
        end
      end
      PH_CAPTURE: if (stb) begin
        exp_q.push_back(w); m_k++;
        if (m_k == 256) m_phase = PH_WAIT;
      end
      default: ;
    endcase
    if (stb) begin m_prev = s; m_prev_valid = 1'b1; end
    @(posedge clk); #1;
    wif.new_sample_ready = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    wr_t w;
    if (wif.write_enable === 1'b1) begin
      w = {wif.write_address, wif.write_sample, wif.write_sample_v1,
           wif.write_sample_v2, wif.write_sample_v3};
      act_q.push_back(w);
    end
    if (wif.capture_done === 1'b1) done_seen++;
  end

  task automatic test_reset();
    reset = 1'b1;
    wif.new_sample_ready = 1'b0; wif.new_sample_in = '0; wif.wave_display_idle = 1'b0;
    wif.sample_v1 = '0; wif.sample_v2 = '0; wif.sample_v3 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compared++; if (wif.write_address !== 9'h000) begin mismatched++; $display("FAIL reset_addr: got %h want 000", wif.write_address); end
    compared++; if (wif.write_enable !== 1'b0) begin mismatched++; $display("FAIL reset_we: got %b want 0", wif.write_enable); end
    compared++; if ({wif.write_sample, wif.write_sample_v1, wif.write_sample_v2, wif.write_sample_v3} !== 32'h0) begin
      mismatched++; $display("FAIL reset_data: got %h %h %h %h want 0", wif.write_sample, wif.write_sample_v1, wif.write_sample_v2, wif.write_sample_v3); end
    compared++; if (wif.read_index !== 1'b0) begin mismatched++; $display("FAIL reset_ri: got %b want 0", wif.read_index); end
    compared++; if (wif.capture_done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", wif.capture_done); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_no_trigger();
    drive(1'b1, 16'd10, 1'b0); drive(1'b1, 16'd20, 1'b0); drive(1'b1, 16'd30, 1'b0);
    repeat (5) drive(1'b1, 16'($urandom_range(1, 32767)), 1'b0);
    drive(1'b0, '0, 1'b0);
    compared++; if (act_q.size() != 0) begin mismatched++; $display("FAIL no_trig_writes: got %0d want 0", act_q.size()); end
    compared++; if (wif.write_enable !== 1'b0) begin mismatched++; $display("FAIL no_trig_we: got %b want 0", wif.write_enable); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_capture();
    repeat ($urandom_range(1, 4)) drive(1'b1, 16'($urandom_range(1, 32767)), 1'b0);
    drive(1'b1, 16'hFF9C, 1'b0);                 // -100
    drive(1'b1, 16'd50, 1'b0);                   // +50: crossing
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) drive(1'b0, '0, 1'b0);
      drive(1'b1, 16'($urandom), 1'b0);
    end
    drive(1'b0, '0, 1'b0);
    compared++; if (act_q.size() != exp_q.size()) begin mismatched++; $display("FAIL cap_len: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      compared++; if (act_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL cap_wr[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    if (act_q.size() > 0) begin
      compared++; if ({act_q[0].addr, act_q[0].mix} !== {9'h100, 8'h80}) begin
        mismatched++; $display("FAIL cap_first: got addr %h data %h want 100 80", act_q[0].addr, act_q[0].mix); end
    end
    compared++; if (wif.read_index !== 1'b0) begin mismatched++; $display("FAIL cap_ri: got %b want 0", wif.read_index); end
    compared++; if (done_seen != 0) begin mismatched++; $display("FAIL cap_done: got %0d pulses want 0", done_seen); end
    if (exp_q.size() > 0) last_wr = exp_q[exp_q.size() - 1];
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_wait_hold();
    repeat (1000) drive(1'b1, 16'($urandom), 1'b0);
    drive(1'b0, '0, 1'b0);
    compared++; if (act_q.size() != 0) begin mismatched++; $display("FAIL wait_writes: got %0d want 0", act_q.size()); end
    compared++; if (wif.write_address !== last_wr.addr) begin mismatched++; $display("FAIL wait_addr: got %h want %h", wif.write_address, last_wr.addr); end
    compared++; if ({wif.write_sample, wif.write_sample_v1, wif.write_sample_v2, wif.write_sample_v3} !== {last_wr.mix, last_wr.v1, last_wr.v2, last_wr.v3}) begin
      mismatched++; $display("FAIL wait_data: got %h%h%h%h want %h%h%h%h", wif.write_sample, wif.write_sample_v1, wif.write_sample_v2, wif.write_sample_v3,
                             last_wr.mix, last_wr.v1, last_wr.v2, last_wr.v3); end
    compared++; if (done_seen != 0 || wif.read_index !== 1'b0) begin mismatched++; $display("FAIL wait_flip: got done %0d ri %b want 0 0", done_seen, wif.read_index); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_swap();
    compared++; if (wif.read_index !== 1'b0) begin mismatched++; $display("FAIL swap_pre_ri: got %b want 0", wif.read_index); end
    drive(1'b0, '0, 1'b1);
    compared++; if (wif.read_index !== 1'b1) begin mismatched++; $display("FAIL swap_ri: got %b want 1", wif.read_index); end
    compared++; if (wif.capture_done !== 1'b1) begin mismatched++; $display("FAIL swap_done: got %b want 1", wif.capture_done); end
    drive(1'b0, '0, 1'b0);
    compared++; if (wif.capture_done !== 1'b0) begin mismatched++; $display("FAIL swap_done_len: got %b want 0", wif.capture_done); end
    compared++; if (done_seen != 1) begin mismatched++; $display("FAIL swap_pulses: got %0d want 1", done_seen); end
    drive(1'b1, 16'hFFFF, 1'b0);                 // -1
    drive(1'b1, 16'h0000, 1'b0);                 // 0 is non-negative: crossing
    repeat (99) drive(1'b1, 16'($urandom), 1'b0);
    drive(1'b0, '0, 1'b0);
    compared++; if (act_q.size() != exp_q.size()) begin mismatched++; $display("FAIL swap_len: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      compared++; if (act_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL swap_wr[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    if (act_q.size() > 0) begin
      compared++; if ({act_q[0].addr, act_q[0].mix} !== {9'h000, 8'h80}) begin
        mismatched++; $display("FAIL swap_first: got addr %h data %h want 000 80", act_q[0].addr, act_q[0].mix); end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    #1 reset = 1'b1;
    #1;
    compared++; if (wif.write_address !== 9'h000 || wif.write_enable !== 1'b0) begin
      mismatched++; $display("FAIL rmid_addr_we: got %h %b want 000 0", wif.write_address, wif.write_enable); end
    compared++; if ({wif.write_sample, wif.write_sample_v1, wif.write_sample_v2, wif.write_sample_v3} !== 32'h0) begin
      mismatched++; $display("FAIL rmid_data: got %h %h %h %h want 0", wif.write_sample, wif.write_sample_v1, wif.write_sample_v2, wif.write_sample_v3); end
    compared++; if (wif.read_index !== 1'b0 || wif.capture_done !== 1'b0) begin
      mismatched++; $display("FAIL rmid_ri_done: got %b %b want 0 0", wif.read_index, wif.capture_done); end
    model_reset();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 16'd5, 1'b0);
    drive(1'b1, 16'hFED4, 1'b0);                 // -300
    drive(1'b1, 16'd7, 1'b0);
    repeat (255) drive(1'b1, 16'($urandom), 1'b0);
    drive(1'b0, '0, 1'b0);
    compared++; if (act_q.size() != exp_q.size()) begin mismatched++; $display("FAIL rmid_len: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      compared++; if (act_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL rmid_wr[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    if (act_q.size() > 0) begin
      compared++; if ({act_q[0].addr, act_q[0].mix} !== {9'h100, 8'h80}) begin
        mismatched++; $display("FAIL rmid_first: got addr %h data %h want 100 80", act_q[0].addr, act_q[0].mix); end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int base_seen, base_model;
    base_seen  = done_seen;
    base_model = m_done;
    for (int i = 0; i < 4000; i++)
      drive($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 7) == 0);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    compared++; if (act_q.size() != exp_q.size()) begin mismatched++; $display("FAIL rand_len: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      compared++; if (act_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL rand_wr[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    compared++; if (wif.read_index !== m_ri) begin mismatched++; $display("FAIL rand_ri: got %b want %b", wif.read_index, m_ri); end
    compared++; if (done_seen - base_seen != m_done - base_model) begin
      mismatched++; $display("FAIL rand_done: got %0d pulses want %0d", done_seen - base_seen, m_done - base_model); end
    act_q.delete(); exp_q.delete();
  endtask

`ifdef WAVE_CAPTURE_AUTOTRIG_EN
  task automatic test_autotrig();
    #1 reset = 1'b1;
    model_reset();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    act_q.delete(); exp_q.delete();
    repeat (TB_TIMEOUT - 1) drive(1'b1, 16'h1000, 1'b0);
    drive(1'b0, '0, 1'b0);
    compared++; if (act_q.size() != 0) begin mismatched++; $display("FAIL auto_early: got %0d writes want 0", act_q.size()); end
    drive(1'b1, 16'h1000, 1'b0);
    drive(1'b0, '0, 1'b0);
    compared++; if (act_q.size() != 1) begin mismatched++; $display("FAIL auto_fire: got %0d writes want 1", act_q.size()); end
    if (act_q.size() > 0) begin
      compared++; if ({act_q[0].addr, act_q[0].mix} !== {9'h100, 8'h90}) begin
        mismatched++; $display("FAIL auto_first: got addr %h data %h want 100 90", act_q[0].addr, act_q[0].mix); end
    end
    repeat (300) drive(1'b1, 16'h1000, 1'b0);
    drive(1'b0, '0, 1'b0);
    compared++; if (act_q.size() != exp_q.size()) begin mismatched++; $display("FAIL auto_len: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      compared++; if (act_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL auto_wr[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    act_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    m_done = 0;
    test_reset();
    test_no_trigger();
    test_capture();
    test_wait_hold();
    test_swap();
    test_reset_mid();
    test_random();
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
    test_autotrig();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
